// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit for the EX stage; owns HI/LO.
//
// Executes mult/multu/div/divu over a programmable number of busy cycles and
// performs mthi/mtlo as single-edge writes. An in-flight operation can be
// aborted with cancel (exception flush) without touching HI/LO.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   reset     in   synchronous active-low reset
//   start     in   one-cycle pulse issuing mult/multu/div/divu
//   mdu_ctrl  in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   a, b      in   rs / rt operands (WIDTH bits)
//   cancel    in   abort the in-flight operation
//   busy      out  an operation is in flight (registered)
//   stall     out  start | busy (combinational, for the hazard unit)
//   hi, lo    out  HI / LO registers
//
// Build option:
//   MDU_DIV0_HOLD_EN  when defined, divide by zero leaves HI/LO unchanged;
//                     otherwise LO = all-ones and HI = dividend.
module mul_div_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mdu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic              busy_q;

    // Result datapath, driven only by the latched operands.
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               is_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, b_div, q_u, r_u, q_res, r_res;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_we;

    always_comb begin
        // Sign-extended operands multiplied modulo 2^(2W) give the signed product.
        prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

        // One unsigned divider serves both div and divu via sign/magnitude.
        // MIN_INT / -1 falls out naturally: |MIN_INT| / 1 negated is MIN_INT.
        is_signed = (op_q == OpDiv);
        a_neg     = is_signed & a_q[WIDTH-1];
        b_neg     = is_signed & b_q[WIDTH-1];
        a_mag     = a_neg ? -a_q : a_q;
        b_mag     = b_neg ? -b_q : b_q;
        b_zero    = (b_q == '0);
        b_div     = b_zero ? WIDTH'(1) : b_mag;
        q_u       = a_mag / b_div;
        r_u       = a_mag % b_div;
        q_res     = (a_neg ^ b_neg) ? -q_u : q_u;
        r_res     = a_neg ? -r_u : r_u;

        res_we = 1'b1;
        res_hi = '0;
        res_lo = '0;
        case (op_q)
            OpMult:  {res_hi, res_lo} = prod_s;
            OpMultu: {res_hi, res_lo} = prod_u;
            OpDiv, OpDivu: begin
                if (b_zero) begin
`ifdef MDU_DIV0_HOLD_EN
                    res_we = 1'b0;
`else
                    res_hi = a_q;
                    res_lo = '1;
`endif
                end else begin
                    res_hi = r_res;
                    res_lo = q_res;
                end
            end
            default: res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && !cancel && (mdu_ctrl inside {OpMult, OpMultu, OpDiv, OpDivu})) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= mdu_ctrl;
                        cnt_q   <= (mdu_ctrl == OpMult || mdu_ctrl == OpMultu) ?
                                   CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end else if (!start && mdu_ctrl == OpMthi) begin
                        hi_q <= a;
                    end else if (!start && mdu_ctrl == OpMtlo) begin
                        lo_q <= a;
                    end
                end
                StRun: begin
                    if (cancel) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                        // This edge takes the counter to zero: commit and leave.
                        if (cnt_q == CntW'(1)) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            if (res_we) begin
                                hi_q <= res_hi;
                                lo_q <= res_lo;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign stall = start | busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
`timescale 1ns/1ps
module tb_mul_div_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start, cancel;
    logic [3:0]  mdu_ctrl;
    logic [31:0] a, b;
    logic        busy, stall;
    logic [31:0] hi, lo;

    logic        start16, cancel16;
    logic [3:0]  ctrl16;
    logic [15:0] a16, b16;
    logic        busy16, stall16;
    logic [15:0] hi16, lo16;

    mul_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .mdu_ctrl(mdu_ctrl), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    mul_div_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .mdu_ctrl(ctrl16), .a(a16), .b(b16),
        .cancel(cancel16), .busy(busy16), .stall(stall16), .hi(hi16), .lo(lo16)
    );

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] mhi = '0, mlo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hazard contract: nothing is issued to the unit while it is busy.
    always @(posedge clk) begin
        if (reset && busy && (start || mdu_ctrl == 4'd5 || mdu_ctrl == 4'd6)) begin
            n_fails++;
            $display("FAIL hazard: issue while busy (start=%0b ctrl=%0d)", start, mdu_ctrl);
        end
    end

    // Reference model: full-precision 64-bit arithmetic on the architectural HI/LO.
    function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sp;
        longint unsigned up;
        case (op)
            4'd1: begin sp = longint'($signed(x)) * longint'($signed(y)); {mhi, mlo} = sp; end
            4'd2: begin up = {32'b0, x} * {32'b0, y}; {mhi, mlo} = up; end
            4'd3, 4'd4: begin
                if (y == 0) begin
`ifndef MDU_DIV0_HOLD_EN
                    mlo = '1;
                    mhi = x;
`endif
                end else if (op == 4'd3) begin
                    sp  = longint'($signed(x)) / longint'($signed(y));
                    mlo = sp[31:0];
                    sp  = longint'($signed(x)) % longint'($signed(y));
                    mhi = sp[31:0];
                end else begin
                    mlo = x / y;
                    mhi = x % y;
                end
            end
            4'd5: mhi = x;
            4'd6: mlo = x;
            default: ;
        endcase
    endfunction

    // Issue a multi-cycle op, count busy cycles, then check HI/LO.
    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input int ncyc,
                         input logic [31:0] ehi, input logic [31:0] elo);
        int cnt = 0;
        start = 1'b1; mdu_ctrl = op; a = x; b = y;
        #1;
        chk({name, " stall@start"}, 64'(stall), 64'(1));
        @(posedge clk); #1;
        start = 1'b0; mdu_ctrl = 4'd0; a = $urandom; b = $urandom;
        while (busy === 1'b1 && cnt < 64) begin
            if (cnt == 0) chk({name, " stall@busy"}, 64'(stall), 64'(1));
            cnt++;
            @(posedge clk); #1;
        end
        chk({name, " busy cycles"}, 64'(cnt), 64'(ncyc));
        chk({name, " hi"}, 64'(hi), 64'(ehi));
        chk({name, " lo"}, 64'(lo), 64'(elo));
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] x, y;
        int          ncyc;
        logic [31:0] ehi, elo;
    } vec_t;

    vec_t        vecs[11];
    logic [3:0]  rop;
    logic [31:0] rx, ry;
    int          cnt16;

    initial begin
        reset = 1'b0; start = 0; cancel = 0; mdu_ctrl = 0; a = 0; b = 0;
        start16 = 0; cancel16 = 0; ctrl16 = 0; a16 = 0; b16 = 0;

        vecs[0]  = '{4'd1, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{4'd4, 32'd100,       32'd7,         10, 32'd2,         32'd14};
        vecs[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
`ifdef MDU_DIV0_HOLD_EN
        vecs[3]  = '{4'd3, 32'd5,         32'd0,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
`else
        vecs[3]  = '{4'd3, 32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF};
`endif
        vecs[4]  = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[5]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000};
        vecs[6]  = '{4'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD};
        vecs[7]  = '{4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFF, 32'd3};
        vecs[8]  = '{4'd1, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'd0};
`ifdef MDU_DIV0_HOLD_EN
        vecs[9]  = '{4'd4, 32'd5,         32'd0,         10, 32'h4000_0000, 32'd0};
`else
        vecs[9]  = '{4'd4, 32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF};
`endif
        vecs[10] = '{4'd2, 32'h1234_5678, 32'h10,        5,  32'd1,         32'h2345_6780};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset stall", 64'(stall), 64'(0));
        chk("reset hi", 64'(hi), 64'(0));
        chk("reset lo", 64'(lo), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven directed vectors.
        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].ncyc,
                  vecs[i].ehi, vecs[i].elo);
            mhi = vecs[i].ehi;
            mlo = vecs[i].elo;
        end

        // mthi then mtlo in consecutive cycles.
        mdu_ctrl = 4'd5; a = 32'h1234;
        @(posedge clk); #1;
        chk("mthi hi", 64'(hi), 64'h1234);
        chk("mthi busy", 64'(busy), 64'(0));
        mdu_ctrl = 4'd6; a = 32'h5678;
        @(posedge clk); #1;
        mdu_ctrl = 4'd0;
        chk("mtlo lo", 64'(lo), 64'h5678);
        chk("mtlo hi", 64'(hi), 64'h1234);
        chk("mtlo busy", 64'(busy), 64'(0));
        mhi = 32'h1234; mlo = 32'h5678;

        // Cancel on the third busy cycle of a mult.
        start = 1'b1; mdu_ctrl = 4'd1; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; mdu_ctrl = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("cancel busy before", 64'(busy), 64'(1));
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel busy after", 64'(busy), 64'(0));
        chk("cancel hi", 64'(hi), 64'(mhi));
        chk("cancel lo", 64'(lo), 64'(mlo));
        model(4'd1, 32'd6, 32'd7);
        do_op("post-cancel", 4'd1, 32'd6, 32'd7, 5, mhi, mlo);

        // Cancel together with start in IDLE drops the start.
        start = 1'b1; cancel = 1'b1; mdu_ctrl = 4'd3; a = 32'd9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0; mdu_ctrl = 4'd0;
        chk("drop start busy", 64'(busy), 64'(0));
        repeat (12) @(posedge clk);
        #1;
        chk("drop start hi", 64'(hi), 64'(mhi));
        chk("drop start lo", 64'(lo), 64'(mlo));

        // Randomised operations against the model.
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(1, 6));
            rx  = $urandom;
            ry  = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: ry = {28'd0, ry[3:0]};
                default: ;
            endcase
            model(rop, rx, ry);
            if (rop <= 4'd4) begin
                do_op($sformatf("rand%0d op%0d", i, rop), rop, rx, ry,
                      (rop <= 4'd2) ? 5 : 10, mhi, mlo);
            end else begin
                mdu_ctrl = rop; a = rx; b = ry;
                @(posedge clk); #1;
                mdu_ctrl = 4'd0;
                chk($sformatf("rand%0d mt hi", i), 64'(hi), 64'(mhi));
                chk($sformatf("rand%0d mt lo", i), 64'(lo), 64'(mlo));
                chk($sformatf("rand%0d mt busy", i), 64'(busy), 64'(0));
            end
        end

        // Give the 16-bit instance non-zero state, then reset mid-div.
        ctrl16 = 4'd5; a16 = 16'hBEEF;
        @(posedge clk); #1;
        ctrl16 = 4'd0;
        chk("w16 mthi", 64'(hi16), 64'hBEEF);
        mdu_ctrl = 4'd6; a = 32'hCAFE_0001;
        @(posedge clk); #1;
        start = 1'b1; mdu_ctrl = 4'd3; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; mdu_ctrl = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid-div busy", 64'(busy), 64'(1));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid-div reset busy", 64'(busy), 64'(0));
        chk("mid-div reset hi", 64'(hi), 64'(0));
        chk("mid-div reset lo", 64'(lo), 64'(0));
        chk("w16 reset hi", 64'(hi16), 64'(0));
        chk("w16 reset busy", 64'(busy16), 64'(0));
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post-reset hi stays 0", 64'(hi), 64'(0));
        chk("post-reset lo stays 0", 64'(lo), 64'(0));

        // WIDTH=16, MULT_CYCLES=1: 0x8000 * 0x8000 signed.
        start16 = 1'b1; ctrl16 = 4'd1; a16 = 16'h8000; b16 = 16'h8000;
        @(posedge clk); #1;
        start16 = 1'b0; ctrl16 = 4'd0; a16 = 16'h1; b16 = 16'h1;
        cnt16 = 0;
        while (busy16 === 1'b1 && cnt16 < 16) begin
            cnt16++;
            @(posedge clk); #1;
        end
        chk("w16 busy cycles", 64'(cnt16), 64'(1));
        chk("w16 hi", 64'(hi16), 64'h4000);
        chk("w16 lo", 64'(lo16), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multi-cycle multiply/divide unit for the EX stage of the pipelined CPU, owning the HI/LO registers. It executes the operations the main controller issues through `MDUCtrl`/`start`: signed and unsigned multiply and divide, plus `mthi`/`mtlo`. It exposes a busy/stall indication so the hazard logic can hold `md`/`mt`/`mf` instructions in D. Compared with a fixed-latency unit, it adds generic width, independent multiply and divide latencies, in-flight cancel for a later exception flush, and configurable divide-by-zero semantics.

## Interface
Parameters:
- `WIDTH`, 32, operand, HI and LO width.
- `MULT_CYCLES`, 5, busy cycles for mult/multu; must be ≥1.
- `DIV_CYCLES`, 10, busy cycles for div/divu; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  high for one cycle with a mult/multu/div/divu in EX.
- `mdu_ctrl`  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; other codes are treated as none.
- `a`  in  WIDTH  rs operand (forwarded).
- `b`  in  WIDTH  rt operand (forwarded).
- `cancel`  in  1  abort the in-flight operation (exception flush).
- `busy`  out  1  an operation is in flight.
- `stall`  out  1  `start | busy`; combinational; consumed by the hazard unit.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE and RUN, with a down-counter wide enough for max(`MULT_CYCLES`, `DIV_CYCLES`).
- In IDLE, when `start` is high and `mdu_ctrl` is 1–4:
  - latch `a`, `b` and the opcode;
  - load the counter with the op latency;
  - go to RUN.
- In IDLE, when `start` is low and `mdu_ctrl` is 5 or 6: write `a` into HI or LO at this edge.
- In RUN:
  - the counter decrements each cycle;
  - on the edge where the counter reaches 0, commit HI/LO from the latched operands and return to IDLE.
- Inputs ignored while in RUN: `start`, `mthi` and `mtlo`. The hazard unit guarantees they are not issued; the bench asserts that.
- `cancel` in RUN: go to IDLE next edge; HI/LO are unchanged. `cancel` in IDLE has no effect.
- `cancel` together with `start` in IDLE: the start is dropped.
- Arithmetic:
  - mult: {HI,LO} = signed 2·WIDTH product.
  - multu: {HI,LO} = unsigned 2·WIDTH product.
  - div: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div with MIN_INT / −1: LO = MIN_INT, HI = 0.
- Divide by zero: see Configuration.
- Results are computed from latched operands only. Later changes on `a`/`b` do not affect them.
- Reset (active, any state, including mid-operation): state IDLE, counter 0, `busy`=0, `hi`=0, `lo`=0, latched operands 0.

## Timing
- `start` sampled at edge E: `busy`=1 for exactly N cycles after E (N = `MULT_CYCLES` or `DIV_CYCLES`). New HI/LO are visible in the first cycle after `busy` falls.
- `stall` is high during the `start` cycle and all N busy cycles. An `mfhi` held in D therefore reads the committed value.
- mthi/mtlo: HI/LO are updated at the sampling edge and visible the next cycle; `busy` stays 0.
- Back-to-back: a new `start` is accepted in the first cycle after `busy` falls.
- `cancel` with `busy`=1 at edge C: `busy`=0 from C+1.

## Configuration
- `MDU_DIV0_HOLD_EN` defined: div/divu with `b`=0 still occupy N busy cycles, but HI and LO keep their previous values.
- Undefined (default): divide by zero writes LO = all-ones and HI = dividend (`a` latched), for both div and divu.

## Test plan
- Reset then mult, `a`=0xFFFFFFFE, `b`=3, default params → `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- divu, `a`=100, `b`=7 → `busy` high 10 cycles; then LO=14, HI=2. Repeat with div, `a`=−7, `b`=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi `a`=0x1234, then mtlo `a`=0x5678 in consecutive cycles → HI=0x1234 and LO=0x5678, each visible the next cycle; `busy` never asserts.
- mult in flight, `cancel` on the third busy cycle → `busy` falls the next cycle; HI/LO keep their prior values; a new `start` is accepted immediately.
- div, `a`=5, `b`=0 → with `MDU_DIV0_HOLD_EN` HI/LO unchanged; without it LO=0xFFFFFFFF, HI=5.
- `reset` asserted mid-div, then `WIDTH`=16 / `MULT_CYCLES`=1 instance → all outputs 0 after reset; mult of 0x8000 × 0x8000 → HI=0x4000, LO=0, `busy` high exactly 1 cycle.
